// File: rtl/conv_pkg.sv
// Shared types and word-layout constants for the convolution input stream.
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StKick,
    StBurst,
    StGap,
    StDrain,
    StWaitDone
  } state_e;

  localparam int unsigned CH1_LSB       = 0;
  localparam int unsigned CH2_LSB       = 16;
  localparam int unsigned CH_W          = 16;
  localparam int unsigned LB_LEN        = 4;
  localparam int unsigned BURST_DEFAULT = 16;

endpackage

// File: rtl/stream_rd_pipe.sv
// Two-stage alignment of SRAM read data to the conv_num stream; flush drops in-flight reads.
module stream_rd_pipe
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        mem_req,
  input  logic [31:0] mem_rdata,
  output logic [31:0] conv_num,
  output logic        conv_num_valid
);

  logic rd_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q       <= 1'b0;
      conv_num_valid <= 1'b0;
      conv_num       <= '0;
    end else begin
      rd_vld_q       <= mem_req & ~flush;
      conv_num_valid <= rd_vld_q & ~flush;
      // conv_num holds its last value whenever no word is delivered.
      if (rd_vld_q && !flush) begin
        conv_num <= {mem_rdata[CH2_LSB +: CH_W], mem_rdata[CH1_LSB +: CH_W]};
      end
    end
  end

endmodule

// File: rtl/ifmap_streamer.sv
// Streams a packed feature map from SRAM to the convolution controller in gapped bursts.
module ifmap_streamer
  import conv_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  pix_total,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [CNT_W-1:0]  gap_len,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              start,
  output logic [31:0]       conv_num,
  output logic              conv_num_valid,
  input  logic              conv_done,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, mem_addr_d;
  logic [CNT_W-1:0]  total_q, total_d, blen_q, blen_d, gap_q, gap_d;
  logic [CNT_W-1:0]  sent_q, sent_d, bcnt_q, bcnt_d, gcnt_q, gcnt_d;
  logic [CNT_W-1:0]  blen_eff;
  logic [CNT_W:0]    sent_inc, bcnt_inc, gcnt_inc;
  logic              flag_q, flag_d, done_d;

  assign blen_eff = (blen_q == '0) ? CNT_W'(1) : blen_q;
  assign sent_inc = {1'b0, sent_q} + (CNT_W + 1)'(1);
  assign bcnt_inc = {1'b0, bcnt_q} + (CNT_W + 1)'(1);
  assign gcnt_inc = {1'b0, gcnt_q} + (CNT_W + 1)'(1);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    total_d = total_q;
    blen_d  = blen_q;
    gap_d   = gap_q;
    sent_d  = sent_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    flag_d  = flag_q;
    done_d  = 1'b0;

    if (conv_done && (state_q inside {StKick, StBurst, StGap, StDrain})) flag_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (go && !abort) begin
          base_d  = base_addr;
          total_d = pix_total;
          blen_d  = burst_len;
          gap_d   = gap_len;
          sent_d  = '0;
          bcnt_d  = '0;
          gcnt_d  = '0;
          if (pix_total == '0) done_d = 1'b1;
          else state_d = StKick;
        end
      end
      StKick: state_d = StBurst;
      StBurst: begin
        sent_d = sent_inc[CNT_W-1:0];
        if (sent_inc == {1'b0, total_q}) begin
          state_d = StDrain;
          gcnt_d  = '0;
        end else if (bcnt_inc == {1'b0, blen_eff}) begin
          bcnt_d = '0;
          gcnt_d = '0;
          if (gap_q != '0) state_d = StGap;
        end else begin
          bcnt_d = bcnt_inc[CNT_W-1:0];
        end
      end
      StGap: begin
        if (gcnt_inc == {1'b0, gap_q}) begin
          state_d = StBurst;
          bcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_inc[CNT_W-1:0];
        end
      end
      // Two cycles let the last request clear the read pipeline.
      StDrain: begin
        if (gcnt_inc == (CNT_W + 1)'(2)) state_d = StWaitDone;
        else gcnt_d = gcnt_inc[CNT_W-1:0];
      end
      StWaitDone: begin
        if (conv_done || flag_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
    if (state_d == StIdle) flag_d = 1'b0;

    mem_addr_d = mem_addr;
    if (state_d == StBurst) mem_addr_d = base_d + sent_d[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      base_q   <= '0;
      total_q  <= '0;
      blen_q   <= '0;
      gap_q    <= '0;
      sent_q   <= '0;
      bcnt_q   <= '0;
      gcnt_q   <= '0;
      flag_q   <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      total_q  <= total_d;
      blen_q   <= blen_d;
      gap_q    <= gap_d;
      sent_q   <= sent_d;
      bcnt_q   <= bcnt_d;
      gcnt_q   <= gcnt_d;
      flag_q   <= flag_d;
      mem_req  <= (state_d == StBurst);
      mem_addr <= mem_addr_d;
      start    <= (state_d == StKick);
      busy     <= (state_d != StIdle);
      done     <= done_d;
    end
  end

  stream_rd_pipe u_rd_pipe (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (abort),
    .mem_req        (mem_req),
    .mem_rdata      (mem_rdata),
    .conv_num       (conv_num),
    .conv_num_valid (conv_num_valid)
  );

endmodule

// File: tb/tb_ifmap_streamer.sv
// Scoreboard bench for ifmap_streamer: 12-bit main instance plus a 4-bit instance for wrap.
module tb_ifmap_streamer;

  logic        clk, rst_n, go, abort, conv_done, go4;
  logic [11:0] base_addr, mem_addr;
  logic [15:0] pix_total, burst_len, gap_len;
  logic        mem_req, start, conv_num_valid, busy, done;
  logic [31:0] mem_rdata, conv_num;
  logic [3:0]  base4, mem_addr4;
  logic        mem_req4, start4, conv_num_valid4, busy4, done4;
  logic [31:0] mem_rdata4, conv_num4;

  int          n_cmp = 0, n_err = 0;
  int          n_start = 0, n_req = 0, n_done = 0;
  logic [31:0] exp_q[$];
  int          runs_q[$], idles_q[$];
  int          cur_run = 0, cur_idle = 0;
  bit          prev_valid = 1'b0;

  ifmap_streamer #(.ADDR_W(12), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .base_addr(base_addr),
    .pix_total(pix_total), .burst_len(burst_len), .gap_len(gap_len),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .start(start),
    .conv_num(conv_num), .conv_num_valid(conv_num_valid), .conv_done(conv_done),
    .busy(busy), .done(done)
  );

  ifmap_streamer #(.ADDR_W(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .go(go4), .abort(abort), .base_addr(base4),
    .pix_total(pix_total), .burst_len(burst_len), .gap_len(gap_len),
    .mem_req(mem_req4), .mem_addr(mem_addr4), .mem_rdata(mem_rdata4), .start(start4),
    .conv_num(conv_num4), .conv_num_valid(conv_num_valid4), .conv_done(conv_done),
    .busy(busy4), .done(done4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM models: SRAM[a] = a for the main instance
  always @(posedge clk) if (mem_req) mem_rdata <= 32'(mem_addr);
  always @(posedge clk) if (mem_req4) mem_rdata4 <= {16'h00A5, 12'h000, mem_addr4};

  // Scoreboard and run/idle tracking of the output stream
  always @(negedge clk) begin
    if (rst_n) begin
      if (start) n_start++;
      if (mem_req) n_req++;
      if (done) n_done++;
      if (conv_num_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra: got word %h, required no word", conv_num);
        end else begin
          logic [31:0] want;
          want = exp_q.pop_front();
          if (conv_num !== want) begin
            n_err++;
            $display("FAIL sb_word: got %h, required %h", conv_num, want);
          end
        end
        if (!prev_valid) idles_q.push_back(cur_idle);
        cur_run++;
        cur_idle = 0;
      end else begin
        if (prev_valid) begin
          runs_q.push_back(cur_run);
          cur_run = 0;
        end
        cur_idle++;
      end
      prev_valid = conv_num_valid;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [11:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [11:0] a;
      a = base + 12'(i);
      exp_q.push_back(32'(a));
    end
  endtask

  task automatic launch(input logic [11:0] b, input logic [15:0] n, input logic [15:0] bl,
                        input logic [15:0] gl);
    base_addr = b;
    pix_total = n;
    burst_len = bl;
    gap_len   = gl;
    push_exp(b, int'(n));
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_drained(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic pulse_conv_done();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({mem_req, mem_addr, start, conv_num, conv_num_valid, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_main: got %b%h%b%h%b%b%b, required all zero", mem_req, mem_addr,
               start, conv_num, conv_num_valid, busy, done);
    end
    n_cmp++;
    if ({mem_req4, mem_addr4, start4, conv_num4, conv_num_valid4, busy4, done4} !== '0) begin
      n_err++;
      $display("FAIL reset_w4: got outputs nonzero, required all zero");
    end
  endtask

  task automatic test_basic();
    int s0 = n_start;
    int r0 = runs_q.size();
    launch(12'h010, 16'd10, 16'd16, 16'd0);
    n_cmp++;
    if (start !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_kick: start=%b req=%b busy=%b, required 1 0 1", start, mem_req, busy);
    end
    tick();
    n_cmp++;
    if (start !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 12'h010) begin
      n_err++;
      $display("FAIL basic_first_req: start=%b req=%b addr=%h, required 0 1 010", start, mem_req,
               mem_addr);
    end
    tick();
    tick();
    n_cmp++;
    if (conv_num_valid !== 1'b1) begin
      n_err++;
      $display("FAIL basic_first_valid: valid=%b, required 1", conv_num_valid);
    end
    wait_drained(40);
    repeat (3) tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_wait: done=%b busy=%b, required 0 1", done, busy);
    end
    pulse_conv_done();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: done=%b busy=%b, required 1 0", done, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_pulse: done=%b, required 0", done);
    end
    n_cmp++;
    if (n_start - s0 != 1 || runs_q.size() - r0 != 1 || runs_q[r0] != 10) begin
      n_err++;
      $display("FAIL basic_shape: starts=%0d runs=%0d len=%0d, required 1 1 10", n_start - s0,
               runs_q.size() - r0, runs_q[r0]);
    end
  endtask

  task automatic test_gaps();
    int r0 = runs_q.size();
    int i0 = idles_q.size();
    launch(12'h200, 16'd40, 16'd16, 16'd5);
    repeat (6) tick();
    base_addr = 12'h300;  // a go while busy must leave the latched config alone
    pix_total = 16'd3;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_drained(150);
    n_cmp++;
    if (runs_q.size() - r0 != 3 || runs_q[r0] != 16 || runs_q[r0+1] != 16 || runs_q[r0+2] != 8)
    begin
      n_err++;
      $display("FAIL gaps_runs: n=%0d %0d/%0d/%0d, required 3 16/16/8", runs_q.size() - r0,
               runs_q[r0], runs_q[r0+1], runs_q[r0+2]);
    end
    n_cmp++;
    if (idles_q[i0+1] != 5 || idles_q[i0+2] != 5) begin
      n_err++;
      $display("FAIL gaps_idle: %0d/%0d, required 5/5", idles_q[i0+1], idles_q[i0+2]);
    end
    pulse_conv_done();
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL gaps_done: done=%b, required 1", done);
    end
    tick();
  endtask

  task automatic test_edge();
    int s0 = n_start;
    int q0 = n_req;
    int r0, i0, ones;
    launch(12'h050, 16'd0, 16'd16, 16'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin
      n_err++;
      $display("FAIL edge_zero_done: done=%b busy=%b start=%b, required 1 0 0", done, busy, start);
    end
    repeat (4) tick();
    n_cmp++;
    if (n_start != s0 || n_req != q0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL edge_zero_quiet: starts=%0d reqs=%0d done=%b, required 0 0 0", n_start - s0,
               n_req - q0, done);
    end
    r0 = runs_q.size();
    i0 = idles_q.size();
    launch(12'h060, 16'd4, 16'd0, 16'd3);
    wait_drained(60);
    ones = 0;
    for (int i = 0; i < 4; i++) if (runs_q[r0+i] == 1) ones++;
    n_cmp++;
    if (runs_q.size() - r0 != 4 || ones != 4) begin
      n_err++;
      $display("FAIL edge_burst0_runs: runs=%0d singles=%0d, required 4 4", runs_q.size() - r0,
               ones);
    end
    n_cmp++;
    if (idles_q[i0+1] != 3 || idles_q[i0+2] != 3 || idles_q[i0+3] != 3) begin
      n_err++;
      $display("FAIL edge_burst0_gap: %0d/%0d/%0d, required 3/3/3", idles_q[i0+1],
               idles_q[i0+2], idles_q[i0+3]);
    end
    pulse_conv_done();
    tick();
  endtask

  task automatic test_early_done();
    int d0;
    launch(12'h080, 16'd20, 16'd16, 16'd0);
    repeat (4) tick();
    pulse_conv_done();
    repeat (18) tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL early_not_yet: done=%b busy=%b, required 0 1", done, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL early_done: done=%b busy=%b, required 1 0", done, busy);
    end
    wait_drained(5);
    d0 = n_done;
    launch(12'h0A0, 16'd2, 16'd16, 16'd0);
    repeat (12) tick();
    n_cmp++;
    if (busy !== 1'b1 || n_done != d0) begin
      n_err++;
      $display("FAIL early_flag_clear: busy=%b dones=%0d, required 1 0", busy, n_done - d0);
    end
    pulse_conv_done();
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL early_second_done: done=%b, required 1", done);
    end
    tick();
  endtask

  task automatic test_abort();
    int d0 = n_done;
    int k = 0;
    int s0, q0;
    launch(12'h100, 16'd20, 16'd16, 16'd0);
    while (!(mem_req === 1'b1 && mem_addr === 12'h106) && k < 30) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k >= 30) begin
      n_err++;
      $display("FAIL abort_reach: word 7 never requested, required within 30 cycles");
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b0 || conv_num_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_quiet: req=%b valid=%b busy=%b, required 0 0 0", mem_req,
               conv_num_valid, busy);
    end
    n_cmp++;
    if (exp_q.size() != 15) begin
      n_err++;
      $display("FAIL abort_delivered: %0d words delivered, required 5", 20 - exp_q.size());
    end
    exp_q.delete();
    repeat (6) tick();
    n_cmp++;
    if (n_done != d0 || conv_num_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: dones=%0d valid=%b, required 0 0", n_done - d0,
               conv_num_valid);
    end
    launch(12'h100, 16'd3, 16'd16, 16'd0);
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h100) begin
      n_err++;
      $display("FAIL abort_restart: req=%b addr=%h, required 1 100", mem_req, mem_addr);
    end
    wait_drained(20);
    pulse_conv_done();
    tick();
    s0 = n_start;
    q0 = n_req;
    pix_total = 16'd5;
    go = 1'b1;
    abort = 1'b1;
    tick();
    go = 1'b0;
    abort = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (busy !== 1'b0 || n_start != s0 || n_req != q0) begin
      n_err++;
      $display("FAIL abort_beats_go: busy=%b starts=%0d reqs=%0d, required 0 0 0", busy,
               n_start - s0, n_req - q0);
    end
  endtask

  task automatic test_wrap_reset();
    logic [3:0] want [4];
    int got = 0;
    want = '{4'hE, 4'hF, 4'h0, 4'h1};
    base4 = 4'hE;
    pix_total = 16'd4;
    burst_len = 16'd16;
    gap_len = 16'd0;
    go4 = 1'b1;
    tick();
    go4 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mem_req4 === 1'b1 && got < 4) begin
        n_cmp++;
        if (mem_addr4 !== want[got]) begin
          n_err++;
          $display("FAIL wrap_addr%0d: got %h, required %h", got, mem_addr4, want[got]);
        end
        got++;
      end
      tick();
    end
    n_cmp++;
    if (got != 4) begin
      n_err++;
      $display("FAIL wrap_count: %0d requests, required 4", got);
    end
    pulse_conv_done();
    n_cmp++;
    if (done4 !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_done: done=%b, required 1", done4);
    end
    tick();
    base4 = 4'h0;
    launch(12'h1F0, 16'd20, 16'd16, 16'd0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_addr, start, conv_num, conv_num_valid, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_burst: req=%b addr=%h num=%h valid=%b busy=%b, required zero",
               mem_req, mem_addr, conv_num, conv_num_valid, busy);
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || conv_num_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stays_idle: busy=%b req=%b valid=%b, required 0 0 0", busy, mem_req,
               conv_num_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    go = 1'b0;
    go4 = 1'b0;
    abort = 1'b0;
    conv_done = 1'b0;
    base_addr = '0;
    base4 = '0;
    pix_total = '0;
    burst_len = '0;
    gap_len = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_edge();
    test_early_done();
    test_abort();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifmap_streamer.md
# ifmap_streamer

Transmit side of the convolution input stream. Reads a packed two-channel input feature map from a word-addressed SRAM and drives the `conv_num` / `conv_num_valid` stream, plus the `start` pulse, into the convolution controller. Sends words in bursts separated by programmable idle gaps, matching the controller's line-buffer fill / compute cadence. Waits for the controller's `done` before reporting completion.

## Interface
Parameters:
- ADDR_W, 12, SRAM word-address width
- CNT_W, 16, width of all length/count inputs

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- go  in  1  single-cycle request to start a transfer; ignored while busy
- abort  in  1  cancel the transfer; no done is produced
- base_addr  in  ADDR_W  first SRAM word address
- pix_total  in  CNT_W  number of 32-bit words to stream
- burst_len  in  CNT_W  words per burst; 0 is treated as 1
- gap_len  in  CNT_W  idle cycles between bursts
- mem_req  out  1  SRAM read strobe
- mem_addr  out  ADDR_W  SRAM read address
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_req
- start  out  1  one-cycle kick to the convolution controller
- conv_num  out  32  stream word: [15:0] channel 1, [31:16] channel 2
- conv_num_valid  out  1  stream word qualifier
- conv_done  in  1  controller completion pulse
- busy  out  1  high from go acceptance until done or abort
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, KICK, BURST, GAP, DRAIN, WAIT_DONE.
- **IDLE**
  - On go: latch base_addr, pix_total, burst_len and gap_len.
  - If pix_total==0: pulse done next cycle and stay in IDLE; no start is issued.
  - Otherwise go to KICK.
- **KICK**: start=1 for exactly one cycle, then BURST.
- **BURST**
  - mem_req=1 every cycle; mem_addr = base_addr + sent_cnt, wrapping modulo 2^ADDR_W.
  - sent_cnt and burst_cnt increment each cycle.
  - When sent_cnt reaches pix_total: go to DRAIN.
  - Else when burst_cnt reaches burst_len: go to GAP if gap_len>0, otherwise start a new BURST with no idle cycle.
- **GAP**: mem_req=0 for exactly gap_len cycles, then BURST with burst_cnt cleared.
- **DRAIN**: wait until the read pipeline is empty (2 cycles), then WAIT_DONE.
- **WAIT_DONE**: on conv_done (live, or latched earlier), pulse done, then IDLE.
- conv_done arriving in any busy state before WAIT_DONE sets a sticky flag. The flag clears on entry to IDLE.
- **abort**, any state: next cycle the state is IDLE, mem_req=0, conv_num_valid=0 and the read pipeline is flushed. No done pulse.
- Simultaneous go and abort in IDLE: abort wins; go is dropped.
- go while busy: ignored; the latched configuration is unchanged.

## Timing
- Reset values: mem_req=0, mem_addr=0, start=0, conv_num=0, conv_num_valid=0, busy=0, done=0. State is IDLE, all counters 0, sticky flag 0.
- All outputs are registered.
- go sampled at edge E0:
  - start high during E0..E1.
  - First mem_req high during E1..E2.
  - First conv_num_valid high during E3..E4.
- Read pipeline latency is 2 cycles from mem_req to conv_num_valid: one cycle SRAM, one cycle output register.
- Ordering and count: conv_num_valid sequence exactly mirrors the mem_req sequence, delayed by 2 cycles.
- conv_num holds its last value when conv_num_valid=0.
- busy rises the cycle after go is accepted and falls in the same cycle done is high.
- Minimum go-to-done time for N words with no gaps: N+4 cycles plus the wait for conv_done.

## Structure
- Shared package conv_pkg holds:
  - the state enum
  - CH1_LSB=0 and CH2_LSB=16 word-layout constants
  - default line-buffer length LB_LEN=4 and burst default 16
- Sub-module stream_rd_pipe: 2-stage valid/data alignment from mem_req and mem_rdata to conv_num and conv_num_valid, with synchronous flush on abort.
- The FSM and counters live in the top module.

## Test plan
- Basic stream: pix_total=10, burst_len=16, gap_len=0, base=0x010, SRAM[a]=a. Expect one start, then 10 consecutive valid words 0x010..0x019. done pulses 1 cycle after conv_done.
- Bursts with gaps: pix_total=40, burst_len=16, gap_len=5. Expect valid runs of 16, 16, 8, separated by exactly 5 idle cycles; addresses contiguous.
- Edge configurations:
  - pix_total=0: done one cycle after go, no start, no mem_req.
  - burst_len=0, gap_len=3: one word then 3 idle cycles, repeating.
- Early conv_done: pulse conv_done during BURST. Expect done right after DRAIN with no further wait; the sticky flag is clear in IDLE afterwards.
- Abort mid-burst at word 7 of 20: mem_req and conv_num_valid are 0 next cycle, at most the 2 in-flight words are dropped, no done, busy=0. A following go restarts from base_addr.
- Address wrap and reset: ADDR_W=4, base=0xE, pix_total=4. Addresses 0xE, 0xF, 0x0, 0x1. Asserting rst_n low mid-burst returns every output to its reset value immediately.
